// File: rtl/instr_dispatch.sv
// Instruction front-end: spreads one upstream instruction per cycle over NUM_CORES per-core FIFOs.
// Latency: an accepted word is visible at the core outputs one cycle later. Counters update on the transfer edge.
// Backpressure: in_ready depends on the FIFO(s) the current mode targets. It is forced low during flush and reset.
module instr_dispatch #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int INSTR_W    = 32,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int TW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W-1:0]           in_instr,
  input  logic [TW-1:0]                in_target,
  output logic [NUM_CORES-1:0]         core_valid,
  input  logic [NUM_CORES-1:0]         core_ready,
  output logic [NUM_CORES*INSTR_W-1:0] core_instr,
  output logic [NUM_CORES*CW-1:0]      fifo_count,
  output logic [15:0]                  accept_count,
  output logic                         err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [INSTR_W-1:0]   mem    [NUM_CORES][FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr [NUM_CORES];
  logic [AW-1:0]        rd_ptr [NUM_CORES];
  logic [CW-1:0]        count  [NUM_CORES];
  logic [TW-1:0]        rr_ptr;
  logic [NUM_CORES-1:0] full;
  logic [NUM_CORES-1:0] rr_hit;
  logic [NUM_CORES-1:0] tgt_hit;
  logic [NUM_CORES-1:0] push;
  logic [NUM_CORES-1:0] pop;
  logic                 ready_raw;
  logic                 accept;
  logic                 bad_req;

  // Per-core decode: full flags and one-hot selects for rr pointer and explicit target.
  // An out-of-range target matches no core, so it can never be accepted.
  always_comb begin
    full    = '0;
    rr_hit  = '0;
    tgt_hit = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      full[i]    = (count[i] == CW'(FIFO_DEPTH));
      rr_hit[i]  = (rr_ptr == TW'(i));
      tgt_hit[i] = (in_target == TW'(i));
    end
  end

  // Upstream handshake, FIFO push/pop selects and illegal-request detection.
  always_comb begin
    ready_raw = 1'b0;
    push      = '0;
    case (mode)
      2'd0:    ready_raw = |(rr_hit & ~full);
      2'd1:    ready_raw = |(tgt_hit & ~full);
      2'd2:    ready_raw = &(~full);
      default: ready_raw = 1'b0;
    endcase
    in_ready = ready_raw && !flush && !reset;
    accept   = in_valid && in_ready;
    if (accept) begin
      case (mode)
        2'd0:    push = rr_hit;
        2'd1:    push = tgt_hit;
        2'd2:    push = '1;
        default: push = '0;
      endcase
    end
    pop     = core_valid & core_ready;
    bad_req = in_valid && ((mode == 2'd3) || ((mode == 2'd1) && !(|tgt_hit)));
  end

  // Head, valid and occupancy outputs come straight from FIFO state, never from in_*.
  always_comb begin
    core_valid = '0;
    core_instr = '0;
    fifo_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_valid[i]                   = (count[i] != '0);
      core_instr[i*INSTR_W +: INSTR_W] = mem[i][rd_ptr[i]];
      fifo_count[i*CW +: CW]           = count[i];
    end
  end

  // FIFO storage: no reset needed, occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= in_instr;
      end
    end
  end

  // FIFO pointers, occupancy, round-robin pointer and sticky error.
  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
      err    <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (accept && (mode == 2'd0)) begin
        rr_ptr <= (rr_ptr == TW'(NUM_CORES - 1)) ? '0 : rr_ptr + TW'(1);
      end
      if (bad_req) err <= 1'b1;
    end
  end

  // Accepted-transfer counter: survives flush, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_count <= '0;
    end else if (accept) begin
      accept_count <= accept_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: directed scenarios plus randomized traffic against a queue-based model.
// Outputs are compared once per cycle away from the clock edge; in_ready is compared after inputs settle.
// Upstream holds a rejected request until it is accepted, except for requests that can never be accepted.
module tb_instr_dispatch;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int W  = 32;
  localparam int CW = 3;
  localparam int TW = 2;

  logic            clk;
  logic            reset;
  logic [1:0]      mode;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_instr;
  logic [TW-1:0]   in_target;
  logic [N-1:0]    core_valid;
  logic [N-1:0]    core_ready;
  logic [N*W-1:0]  core_instr;
  logic [N*CW-1:0] fifo_count;
  logic [15:0]     accept_count;
  logic            err;

  instr_dispatch #(.NUM_CORES(N), .FIFO_DEPTH(D), .INSTR_W(W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_target(in_target),
    .core_valid(core_valid), .core_ready(core_ready), .core_instr(core_instr),
    .fifo_count(fifo_count), .accept_count(accept_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: one queue per core plus scalar state.
  logic [W-1:0] q [N][$];
  int           m_rr  = 0;
  bit           m_err = 0;
  int           m_acc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_ready(input logic [1:0] m, input int t, input bit fl, input bit rs);
    bit r;
    r = 1'b0;
    if (fl || rs) return 1'b0;
    case (m)
      2'd0: r = (q[m_rr].size() < D);
      2'd1: r = (t < N) && (q[t].size() < D);
      2'd2: begin
        r = 1'b1;
        for (int i = 0; i < N; i++) if (q[i].size() >= D) r = 1'b0;
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic model_update(input logic [1:0] m, input bit v, input logic [W-1:0] d, input int t,
                              input logic [N-1:0] cr, input bit fl, input bit rs, input bit rdy);
    bit pf [N];
    if (rs) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_rr = 0; m_err = 0; m_acc = 0;
      return;
    end
    if (fl) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_rr = 0; m_err = 0;
      return;
    end
    for (int i = 0; i < N; i++) pf[i] = (q[i].size() > 0) && cr[i];
    for (int i = 0; i < N; i++) if (pf[i]) void'(q[i].pop_front());
    if (v && rdy) begin
      case (m)
        2'd0: begin q[m_rr].push_back(d); m_rr = (m_rr + 1) % N; end
        2'd1: q[t].push_back(d);
        2'd2: for (int i = 0; i < N; i++) q[i].push_back(d);
        default: ;
      endcase
      m_acc = (m_acc + 1) % 65536;
    end
    if (v && ((m == 2'd3) || ((m == 2'd1) && (t >= N)))) m_err = 1'b1;
  endtask

  task automatic check_state();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("core_valid%0d", i), 128'(core_valid[i]), 128'(q[i].size() > 0));
      chk($sformatf("fifo_count%0d", i), 128'(fifo_count[i*CW +: CW]), 128'(q[i].size()));
      if (q[i].size() > 0)
        chk($sformatf("core_instr%0d", i), 128'(core_instr[i*W +: W]), 128'(q[i][0]));
    end
    chk("accept_count", 128'(accept_count), 128'(m_acc));
    chk("err", 128'(err), 128'(m_err));
  endtask

  // One cycle: drive inputs, check in_ready, clock, update model, check registered state.
  task automatic step(input logic [1:0] m, input bit v, input logic [W-1:0] d, input int t,
                      input logic [N-1:0] cr, input bit fl, input bit rs, output bit accepted);
    bit rdy;
    mode = m; in_valid = v; in_instr = d; in_target = TW'(t);
    core_ready = cr; flush = fl; reset = rs;
    #1;
    rdy = model_ready(m, t, fl, rs);
    chk("in_ready", 128'(in_ready), 128'(rdy));
    accepted = v && rdy;
    @(posedge clk);
    model_update(m, v, d, t, cr, fl, rs, rdy);
    @(negedge clk);
    check_state();
  endtask

  bit acc;
  int accepts;
  int saved_acc;
  logic [1:0]   rm;
  bit           rv;
  logic [W-1:0] rd;
  int           rt;
  bit           pend;

  initial begin
    reset = 1'b1; mode = 2'd0; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_target = '0; core_ready = '0;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'd0);
    check_state();
    step(2'd0, 1'b1, 32'h0, 0, 4'h0, 1'b0, 1'b1, acc);

    // Round-robin fill, cores stalled.
    for (int k = 1; k <= 5; k++) step(2'd0, 1'b1, W'(k * 32'h11), 0, 4'h0, 1'b0, 1'b0, acc);
    chk("rr_counts", 128'(fifo_count), 128'h24A);
    chk("rr_heads", 128'(core_instr), {32'h44, 32'h33, 32'h22, 32'h11});
    chk("rr_acc", 128'(accept_count), 128'd5);

    // Targeted fill to full, then one pop frees a slot.
    step(2'd0, 1'b0, 32'h0, 0, 4'h0, 1'b1, 1'b0, acc);
    accepts = 0;
    for (int k = 1; k <= 6; k++) begin
      step(2'd1, 1'b1, 32'hB0 + W'(k < 5 ? k : 5), 2, 4'h0, 1'b0, 1'b0, acc);
      if (acc) accepts++;
    end
    chk("bp_accepts", 128'(accepts), 128'd4);
    chk("bp_count_full", 128'(fifo_count[2*CW +: CW]), 128'd4);
    step(2'd1, 1'b1, 32'hB5, 2, 4'b0100, 1'b0, 1'b0, acc);
    step(2'd1, 1'b1, 32'hB5, 2, 4'b0000, 1'b0, 1'b0, acc);
    chk("bp_late_accept", 128'(acc), 128'd1);
    chk("bp_count_after", 128'(fifo_count[2*CW +: CW]), 128'd4);
    chk("bp_head_after", 128'(core_instr[2*W +: W]), 128'hB2);

    // Broadcast with core 2 stalled until the first refusal.
    step(2'd0, 1'b0, 32'h0, 0, 4'h0, 1'b1, 1'b0, acc);
    accepts = 0;
    for (int k = 1; k <= 6; k++) begin
      for (int tries = 0; tries < 8; tries++) begin
        step(2'd2, 1'b1, 32'hC0 + W'(k), 0, (accepts >= 4 && tries > 0) ? 4'b1111 : 4'b1011,
             1'b0, 1'b0, acc);
        if (acc) break;
        if (accepts == 4 && tries == 0) chk("bc_stall_after_4", 128'(in_ready), 128'd0);
      end
      if (acc) accepts++;
    end
    chk("bc_accepts", 128'(accepts), 128'd6);

    // Push and pop on a single-entry FIFO in the same cycle.
    step(2'd0, 1'b0, 32'h0, 0, 4'h0, 1'b1, 1'b0, acc);
    step(2'd1, 1'b1, 32'h5A, 1, 4'h0, 1'b0, 1'b0, acc);
    step(2'd1, 1'b1, 32'hA5, 1, 4'b0010, 1'b0, 1'b0, acc);
    chk("pp_count", 128'(fifo_count[1*CW +: CW]), 128'd1);
    chk("pp_head", 128'(core_instr[1*W +: W]), 128'hA5);

    // Error then flush priority.
    step(2'd0, 1'b1, 32'h61, 0, 4'h0, 1'b0, 1'b0, acc);
    step(2'd0, 1'b1, 32'h62, 0, 4'h0, 1'b0, 1'b0, acc);
    step(2'd3, 1'b1, 32'h63, 0, 4'h0, 1'b0, 1'b0, acc);
    chk("mode3_no_accept", 128'(acc), 128'd0);
    chk("mode3_err", 128'(err), 128'd1);
    step(2'd0, 1'b0, 32'h0, 0, 4'h0, 1'b0, 1'b0, acc);
    chk("err_sticky", 128'(err), 128'd1);
    saved_acc = int'(accept_count);
    step(2'd0, 1'b1, 32'h77, 0, 4'hF, 1'b1, 1'b0, acc);
    chk("fl_counts", 128'(fifo_count), 128'd0);
    chk("fl_valid", 128'(core_valid), 128'd0);
    chk("fl_err", 128'(err), 128'd0);
    chk("fl_acc_kept", 128'(accept_count), 128'(saved_acc));
    step(2'd0, 1'b1, 32'h88, 0, 4'h0, 1'b0, 1'b0, acc);
    chk("fl_rr_core0", 128'(fifo_count), 128'h001);
    chk("fl_rr_head0", 128'(core_instr[W-1:0]), 128'h88);

    // Drive accept_count up to 0xFFFF then across the wrap.
    step(2'd0, 1'b0, 32'h0, 0, 4'h0, 1'b1, 1'b0, acc);
    for (int k = 0; k < 70000 && m_acc != 16'hFFFF; k++)
      step(2'd0, 1'b1, W'($urandom), 0, 4'hF, 1'b0, 1'b0, acc);
    chk("acc_ffff", 128'(accept_count), 128'hFFFF);
    step(2'd0, 1'b1, 32'hDEAD, 0, 4'hF, 1'b0, 1'b0, acc);
    chk("acc_wrap", 128'(accept_count), 128'h0);

    // Randomized traffic with occasional flush and one mid-run reset.
    pend = 1'b0; rm = 2'd0; rv = 1'b0; rd = '0; rt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        case ($urandom_range(0, 15))
          0:               rm = 2'd3;
          1, 2, 3, 4:      rm = 2'd2;
          5, 6, 7, 8, 9:   rm = 2'd1;
          default:         rm = 2'd0;
        endcase
        rv = ($urandom_range(0, 3) != 0);
        rd = W'($urandom);
        rt = int'($urandom_range(0, N - 1));
      end
      step(rm, rv, rd, rt, N'($urandom), ($urandom_range(0, 49) == 0), (c == 1500), acc);
      pend = rv && !acc && (rm != 2'd3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
# instr_dispatch

Parametrised instruction front-end that replaces the single fixed-size per-core instruction holding array with NUM_CORES independent FIFOs. It accepts one instruction per cycle from the upstream valid/ready source and distributes it to the cores' instruction inputs. Three modes are supported: round-robin, explicit target and broadcast. It sits between the test/program source and the instr_if ports of the core instances, and adds flush, occupancy reporting and error flagging.

## Interface
- NUM_CORES, 4, number of downstream cores (1..16)
- FIFO_DEPTH, 4, entries per core FIFO (power of two, ≥2)
- INSTR_W, 32, instruction width
- CW = $clog2(FIFO_DEPTH)+1 (derived), TW = max(1,$clog2(NUM_CORES)) (derived)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mode  in  2  0 round-robin, 1 targeted, 2 broadcast, 3 reserved
- flush  in  1  synchronous clear of all FIFOs and rr pointer
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  upstream may transfer this cycle (combinational)
- in_instr  in  INSTR_W  instruction word
- in_target  in  TW  destination core, used in mode 1 only
- core_valid  out  NUM_CORES  FIFO i non-empty
- core_ready  in  NUM_CORES  core i consumes head this cycle
- core_instr  out  NUM_CORES*INSTR_W  head of FIFO i, slice i
- fifo_count  out  NUM_CORES*CW  occupancy of FIFO i, slice i
- accept_count  out  16  accepted upstream transfers, wraps
- err  out  1  sticky: illegal mode or out-of-range target attempted

## Operation
- Accept = in_valid && in_ready. A broadcast accept counts as one transfer.
- in_ready:
  - Mode 0: FIFO[rr_ptr] not full.
  - Mode 1: in_target < NUM_CORES and FIFO[in_target] not full.
  - Mode 2: all FIFOs not full.
  - Mode 3: 0.
  - Forced 0 in any cycle with flush=1.
- Write on accept:
  - Mode 0: FIFO[rr_ptr]; rr_ptr advances to (rr_ptr+1) mod NUM_CORES.
  - Mode 1: FIFO[in_target].
  - Mode 2: every FIFO.
- rr_ptr changes only on a mode-0 accept or on flush/reset. Strict order: a full FIFO at rr_ptr stalls upstream even when other FIFOs have space.
- Read: pop FIFO i when core_valid[i] && core_ready[i]. core_ready without core_valid is ignored.
- A push and a pop on the same FIFO in the same cycle leave the count unchanged, and the head advances. A full FIFO never sees a push because in_ready excludes it.
- core_instr[i] is the registered head. It holds its value while core_valid[i]=1 and core_ready[i]=0. Its value is don't-care when the FIFO is empty.
- err sets when in_valid=1 and either mode=3, or mode=1 with in_target ≥ NUM_CORES. err is cleared only by reset or flush.
- flush=1:
  - Next edge: all counts and pointers go to 0, rr_ptr goes to 0, err goes to 0.
  - Same-cycle pushes and pops are discarded; flush has priority.
  - accept_count is not cleared.
- accept_count increments by 1 per accept and wraps 0xFFFF→0x0000.
- Mode may change between any two cycles. The upstream holds mode, in_instr and in_target stable while in_valid=1 and in_ready=0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Outputs: core_valid=0, fifo_count=0, accept_count=0, err=0.
  - Internal: rr_ptr=0.
  - in_ready=0 while reset=1.
  - After release, in_ready follows the mode rules with all FIFOs empty.
- Write-to-output latency is 1 cycle: an instruction accepted at edge N sets core_valid at edge N, visible in cycle N+1. There is no combinational bypass from in_* to core_*.
- Pop latency: a pop at edge N shows the next head (or core_valid=0) from cycle N+1.
- fifo_count and accept_count are registered and update on the same edge as the transfer.
- Throughput: 1 accept per cycle sustained while the targeted FIFO is not full. Each core can pop 1 per cycle independently.
- Reset asserted mid-transfer: the in-flight accept is lost and all FIFO contents are discarded.

## Test plan
- Round-robin fill: reset, mode=0, cores not ready, send 0x11,0x22,0x33,0x44,0x55 -> each core_instr[i] shows 0x11..0x44 respectively, fifo_count={1,1,1,1}, 5th lands in core 0 (count 2), accept_count=5.
- Full backpressure: mode=1, target=2, core 2 not ready, send 6 words -> in_ready drops after 4 accepts, fifo_count[2]=4; raise core_ready[2] one cycle -> pops 1st word, 5th accepted next cycle, count stays 4.
- Broadcast with one slow core: mode=2, cores 0,1,3 always ready, core 2 stalled -> 4 accepts then in_ready=0 until core 2 pops; all cores receive identical sequence in order.
- Simultaneous push/pop at one entry: FIFO 1 count=1, push 0xA5 and pop same cycle -> count stays 1, core_instr[1]=0xA5 next cycle.
- Flush priority: FIFOs partly filled, err=1, assert flush with in_valid=1 -> in_ready=0 that cycle, next cycle all counts 0, core_valid=0, err=0, rr_ptr=0 (next mode-0 write goes to core 0), accept_count unchanged.
- Error and wrap: mode=3 with in_valid=1 -> no accept, err=1 sticky; preload accept_count to 0xFFFF via 65535 accepts then one more -> reads 0x0000.
